ysyx_24080006_mdu_ctrl: RTL

//  Sequencer between the EX-stage issue logic and the iterative multiply/divide unit.

---
 rtl/ysyx_24080006_mdu_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_24080006_mdu_ctrl.sv
// ysyx_24080006_mdu_ctrl
//   Sequencer between EX-stage issue and the iterative multiply/divide unit.
//   Takes one MUL/MULH/DIV/REM request at a time and latches its operands.
//   Drives mdu_valid for the whole multi-cycle run and captures the one-cycle result.
//   Returns the result with valid/ready handshaking.
//   Grants the shared ALU adder to the MDU while a run is in flight.
//   Handles pipeline flush.
//   Answers a repeat of the last request from a 1-entry result cache.
// Ports
//   clock, reset_n          clock, asynchronous active-low reset
//   flush                   kill in-flight/pending request
//   req_valid/req_ready     request handshake; req_a, req_b, req_set = operands/op
//   resp_valid/resp_ready   response handshake; resp_data = result
//   mdu_a, mdu_b, mdu_set   latched operands/op to MDU; mdu_valid = run enable
//   mdu_ready, mdu_o        MDU finish pulse and result (valid only with mdu_ready)
//   adder_grant             shared ALU adder belongs to the MDU
//   perf_busy               saturating count of cycles with mdu_valid=1

package ysyx_24080006_mdu_pkg;
    typedef enum logic [1:0] {
        ALU_MULL = 2'd0,
        ALU_MULH = 2'd1,
        ALU_DIV  = 2'd2,
        ALU_REM  = 2'd3
    } mdu_op_t;

    typedef struct packed {
        mdu_op_t op;
        logic    signed_a;
        logic    signed_b;
    } mdu_set_t;
endpackage

module ysyx_24080006_mdu_ctrl
    import ysyx_24080006_mdu_pkg::*;
#(
    parameter int CACHE_EN = 1,
    parameter int PERF_W   = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_a,
    input  logic [31:0]       req_b,
    input  mdu_set_t          req_set,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic [31:0]       mdu_a,
    output logic [31:0]       mdu_b,
    output mdu_set_t          mdu_set,
    output logic              mdu_valid,
    input  logic              mdu_ready,
    input  logic [31:0]       mdu_o,
    output logic              adder_grant,
    output logic [PERF_W-1:0] perf_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t   state, state_nxt;
    logic     accept;
    logic     cache_hit;
    logic     capture;

    logic        cache_vld;
    logic [31:0] cache_a;
    logic [31:0] cache_b;
    mdu_set_t    cache_set;
    logic [31:0] cache_data;

    assign cache_hit = (CACHE_EN != 0) && cache_vld && (cache_set == req_set) &&
                       (cache_a == req_a) && (cache_b == req_b);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        // reset_n gates req_ready so nothing is accepted while reset is held
        req_ready   = (state == S_IDLE) && !flush && reset_n;
        accept      = req_valid && req_ready;
        mdu_valid   = 1'b0;
        adder_grant = 1'b0;
        resp_valid  = 1'b0;
        capture     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = cache_hit ? S_RESP : S_RUN;
                end
            end
            S_RUN: begin
                mdu_valid   = 1'b1;
                adder_grant = 1'b1;
                if (mdu_ready) begin
                    capture   = !flush;
                    state_nxt = flush ? S_IDLE : S_RESP;
                end else if (flush) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // the MDU cannot be aborted; keep it enabled until it finishes
                mdu_valid   = 1'b1;
                adder_grant = 1'b1;
                if (mdu_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (flush || resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_data  <= '0;
            mdu_a      <= '0;
            mdu_b      <= '0;
            mdu_set    <= '0;
            cache_vld  <= 1'b0;
            cache_a    <= '0;
            cache_b    <= '0;
            cache_set  <= '0;
            cache_data <= '0;
            perf_busy  <= '0;
        end else begin
            if (accept) begin
                mdu_a   <= req_a;
                mdu_b   <= req_b;
                mdu_set <= req_set;
                if (cache_hit) begin
                    resp_data <= cache_data;
                end
            end
            // cache key comes from the latched operands of the finishing run
            if (capture) begin
                resp_data  <= mdu_o;
                cache_vld  <= 1'b1;
                cache_a    <= mdu_a;
                cache_b    <= mdu_b;
                cache_set  <= mdu_set;
                cache_data <= mdu_o;
            end
            if (mdu_valid && (perf_busy != '1)) begin
                perf_busy <= perf_busy + {{(PERF_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
